keypad_scanner: RTL and testbench

Scans a 4x4 matrix hex keypad, the input-side counterpart of the multiplexed seven-segment display driver. It drives one active-low column at a time, samples the four pulled-up active-low rows, and debounces the result over whole scans. Each new key press is reported as a 4-bit hex code with a one-cycle valid pulse. This is the operator entry path into the 6502 system, e.g. for address and data entry shown on the display.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 61 ++++++
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, dimensions and key layout for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int unsigned N_ROWS = 4;
    localparam int unsigned N_COLS = 4;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} cls_e;
    typedef enum logic {IDLE, HELD} state_e;

    // Index is row*4+col; '*' reports as E and '#' as F.
    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        logic [3:0] code;
        unique case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hE;
            4'd13: code = 4'h0;
            4'd14: code = 4'hF;
            4'd15: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debouncer: a classification is stable once seen DEBOUNCE_SCANS scans in a row.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done,
    input  cls_e       cls,
    input  logic [3:0] code,
    output logic       stable,
    output cls_e       stable_cls,
    output logic [3:0] stable_code,
    output logic       upd
);

    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    cls_e          last_cls_q;
    logic [3:0]    last_code_q;
    logic [CW-1:0] count_q, count_d;
    logic          upd_q;
    logic          same;

    // Non-single scans always carry code 0, so one compare covers class and code.
    assign same = (cls == last_cls_q) && (code == last_code_q);

    always_comb begin
        count_d = count_q;
        if (scan_done) begin
            if (!same) begin
                count_d = CW'(1);
            end else if (count_q != CW'(DEBOUNCE_SCANS)) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_cls_q  <= NONE;
            last_code_q <= 4'h0;
            count_q     <= '0;
            upd_q       <= 1'b0;
        end else begin
            count_q <= count_d;
            upd_q   <= scan_done;
            if (scan_done) begin
                last_cls_q  <= cls;
                last_code_q <= code;
            end
        end
    end

    assign stable      = (count_q == CW'(DEBOUNCE_SCANS));
    assign stable_cls  = last_cls_q;
    assign stable_code = last_code_q;
    assign upd         = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, row sampling, debounce and press reporting.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4096,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 32,
    parameter int unsigned REPEAT_RATE    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad
        $error("keypad_scanner: parameter below its minimum");
    end

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] div_q;
    logic [1:0]    col_q;
    logic [3:0]    col_n_q;
    logic [15:0]   snapshot_q;
    logic          scan_done_q;
    logic          tick;

    assign tick = (div_q == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            div_q       <= '0;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            snapshot_q  <= '0;
            scan_done_q <= 1'b0;
        end else begin
            row_s1_q    <= row_n;
            row_s2_q    <= row_s1_q;
            div_q       <= tick ? '0 : div_q + DW'(1);
            scan_done_q <= tick && (col_q == 2'd3);
            if (tick) begin
                snapshot_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
                col_q                          <= col_q + 2'd1;
                col_n_q                        <= {col_n_q[2:0], col_n_q[3]};
            end
        end
    end

    assign col_n = col_n_q;

    // Snapshot bit c*4+r is key (r,c); the key map is indexed r*4+c.
    logic [4:0] n_set;
    logic [3:0] hit;
    cls_e       scan_cls;
    logic [3:0] scan_code;

    always_comb begin
        n_set = '0;
        hit   = '0;
        for (int c = 0; c < N_COLS; c++) begin
            for (int r = 0; r < N_ROWS; r++) begin
                if (snapshot_q[c*N_ROWS+r]) begin
                    n_set = n_set + 5'd1;
                    hit   = 4'(r*N_COLS + c);
                end
            end
        end
        if (n_set == 5'd0) begin
            scan_cls = NONE;
        end else if (n_set == 5'd1) begin
            scan_cls = SINGLE;
        end else begin
            scan_cls = MULTI;
        end
        scan_code = (scan_cls == SINGLE) ? key_lookup(hit) : 4'h0;
    end

    logic       stable;
    cls_e       stable_cls;
    logic [3:0] stable_code;
    logic       upd;

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .scan_done  (scan_done_q),
        .cls        (scan_cls),
        .code       (scan_code),
        .stable     (stable),
        .stable_cls (stable_cls),
        .stable_code(stable_code),
        .upd        (upd)
    );

    state_e     state_q, state_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_down_q, key_down_d;
    logic       rep_fire;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
    logic [RW-1:0] rep_target;

    assign rep_target = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);

    // Counts completed scans in HELD that still show the reported key.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (state_q != HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (upd && stable && stable_cls == SINGLE && stable_code == key_code_q) begin
            if (rep_cnt_q + RW'(1) == rep_target) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (stable && stable_cls == SINGLE) state_d = HELD;
            HELD: if (stable && stable_cls == NONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A different key or a multi-key scan while HELD is ignored until release.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        unique case (state_q)
            IDLE: begin
                if (stable && stable_cls == SINGLE) begin
                    key_code_d  = stable_code;
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                end
            end
            HELD: begin
                if (stable && stable_cls == NONE) begin
                    key_down_d = 1'b0;
                end else if (rep_fire) begin
                    key_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner with a combinational keypad matrix model.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = '0;  // bit r*4+c

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2),
        .REPEAT_DELAY  (3),
        .REPEAT_RATE   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    // Monitor: every key_valid pulse must match the next expected code.
    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL pulse_width: key_valid high for 2+ cycles, required 1");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got code %h, required no pulse", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    errors++;
                    $display("FAIL pulse_code: got %h, required %h", key_code, e);
                end
            end
        end
        prev_valid = key_valid;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Returns on the negedge just after col_n wraps 0111 -> 1110 (a scan has completed).
    task automatic wait_scan();
        logic [3:0] prev;
        bit hit;
        prev = col_n;
        hit  = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            if (col_n == 4'b1110 && prev == 4'b0111) hit = 1'b1;
            prev = col_n;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: got no scan wrap in 64 cycles, required one");
        end
    endtask

    task automatic wait_scans(input int n);
        for (int i = 0; i < n; i++) wait_scan();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_n"}, col_n, 4'b1110);
        check({tag, "_key_code"}, key_code, 4'h0);
        check({tag, "_key_valid"}, {3'b0, key_valid}, 4'h0);
        check({tag, "_key_down"}, {3'b0, key_down}, 4'h0);
    endtask

    initial begin
        logic [3:0] col_exp;
        logic [3:0] one;
        one = 4'b0001;

        // 1: reset state and column walk
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            col_exp = ~(one << ((i / 4) % 4));
            check("col_seq", col_n, col_exp);
        end

        // 2: single long press of r1c2
        wait_scan();
        exp_q.push_back(4'h6);
        pressed[1*4+2] = 1'b1;
        wait_scans(10);
        check("t2_down_held", {3'b0, key_down}, 4'h1);
        check("t2_code_held", key_code, 4'h6);
        pressed = '0;
        wait_scan();
        settle();
        check("t2_down_after_1_none", {3'b0, key_down}, 4'h1);
        wait_scan();
        settle();
        check("t2_down_after_2_none", {3'b0, key_down}, 4'h0);

        // 3: bouncing r3c1, then a solid hold
        wait_scan();
        for (int i = 0; i < 6; i++) begin
            pressed[3*4+1] = (i % 2 == 0);
            wait_scan();
        end
        check("t3_down_bounce", {3'b0, key_down}, 4'h0);
        exp_q.push_back(4'h0);
        pressed[3*4+1] = 1'b1;
        wait_scans(4);
        check("t3_down_held", {3'b0, key_down}, 4'h1);
        check("t3_code_held", key_code, 4'h0);
        pressed = '0;
        wait_scans(3);
        check("t3_down_release", {3'b0, key_down}, 4'h0);

        // 4: two keys ignored, single survivor reported
        pressed[0*4+0] = 1'b1;
        pressed[2*4+3] = 1'b1;
        wait_scans(5);
        check("t4_down_multi", {3'b0, key_down}, 4'h0);
        exp_q.push_back(4'h1);
        pressed[2*4+3] = 1'b0;
        wait_scans(4);
        check("t4_down_single", {3'b0, key_down}, 4'h1);
        check("t4_code_single", key_code, 4'h1);
        pressed = '0;
        wait_scans(3);

        // 5: one-scan release is a bounce; three-scan release is a new press
        exp_q.push_back(4'hA);
        pressed[0*4+3] = 1'b1;
        wait_scans(4);
        pressed[0*4+3] = 1'b0;
        wait_scan();
        check("t5_down_gap_a", {3'b0, key_down}, 4'h1);
        pressed[0*4+3] = 1'b1;
        wait_scan();
        settle();
        check("t5_down_gap_b", {3'b0, key_down}, 4'h1);
        wait_scans(3);
        check("t5_down_gap_c", {3'b0, key_down}, 4'h1);
        check("t5_code", key_code, 4'hA);
        pressed = '0;
        wait_scans(3);
        check("t5_down_released", {3'b0, key_down}, 4'h0);
        exp_q.push_back(4'hA);
        pressed[0*4+3] = 1'b1;
        wait_scans(4);
        check("t5_down_repress", {3'b0, key_down}, 4'h1);
        pressed = '0;
        wait_scans(3);

        // 6: long hold of r2c2 (auto-repeat when enabled), then reset mid-hold
`ifdef KEYPAD_REPEAT_EN
        repeat (4) exp_q.push_back(4'h9);  // scans 2, 5, 7, 9
`else
        exp_q.push_back(4'h9);
`endif
        pressed[2*4+2] = 1'b1;
        wait_scans(10);
        pressed = '0;
        wait_scans(3);
        check("t6_down_release", {3'b0, key_down}, 4'h0);

`ifdef KEYPAD_REPEAT_EN
        repeat (2) exp_q.push_back(4'h9);  // scans 2, 5
`else
        exp_q.push_back(4'h9);
`endif
        pressed[2*4+2] = 1'b1;
        wait_scans(6);
        check("t6_down_before_rst", {3'b0, key_down}, 4'h1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_q.push_back(4'h9);
        wait_scans(3);
        check("t6_down_after_rst", {3'b0, key_down}, 4'h1);
        check("t6_code_after_rst", key_code, 4'h9);
        pressed = '0;
        wait_scans(3);
        check("t6_down_final", {3'b0, key_down}, 4'h0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
